// File: rtl/ivector_rr_dispatch.sv
// ivector_rr_dispatch
//   Method-vector dispatcher. Each say(meth, v) is steered into one of NUM_CHAN
//   per-method circular FIFOs selected by meth. A single round-robin arbiter
//   drains the FIFOs into the heard(meth, v) indication port.
//
// Ports
//   CLK          clock
//   nRST         synchronous active-low reset
//   say__ENA     say invocation (only legal while say__RDY=1)
//   say_meth     target channel index (META_W bits, full-width range check)
//   say_v        payload
//   say__RDY     say acceptable for the presented say_meth (registered count only)
//   heard__ENA   indication valid (heard__RDY & any channel non-empty)
//   heard_meth   granted channel index, zero-extended, 0 when idle
//   heard_v      head entry of the granted channel, 0 when idle
//   heard__RDY   downstream can accept heard
//   nonempty     bit i set when channel i holds at least one entry
//   drop_count   saturating count of out-of-range say calls
module ivector_rr_dispatch #(
    parameter int NUM_CHAN = 10,
    parameter int DEPTH    = 4,
    parameter int DATA_W   = 32,
    parameter int META_W   = 32
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                say__ENA,
    input  logic [META_W-1:0]   say_meth,
    input  logic [DATA_W-1:0]   say_v,
    output logic                say__RDY,
    output logic                heard__ENA,
    output logic [META_W-1:0]   heard_meth,
    output logic [DATA_W-1:0]   heard_v,
    input  logic                heard__RDY,
    output logic [NUM_CHAN-1:0] nonempty,
    output logic [15:0]         drop_count
);

    localparam int CH_W  = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [PTR_W-1:0] PTR_MASK = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CHAN - 1);
    localparam logic [15:0]      DROP_MAX = 16'hFFFF;

    // Storage (never reset) and per-channel bookkeeping
    logic [DATA_W-1:0]   mem_r      [NUM_CHAN][DEPTH];
    logic [PTR_W-1:0]    wr_ptr_r   [NUM_CHAN];
    logic [PTR_W-1:0]    rd_ptr_r   [NUM_CHAN];
    logic [CNT_W-1:0]    count_r    [NUM_CHAN];
    logic [CNT_W-1:0]    count_next_s [NUM_CHAN];
    logic [NUM_CHAN-1:0] nonempty_r;
    logic [CH_W-1:0]     last_grant_r;
    logic [15:0]         drop_count_r;

    logic                say_in_range_s;
    logic [CH_W-1:0]     say_ch_s;
    logic                say_rdy_s;
    logic                say_push_s;
    logic                say_drop_s;
    logic [CH_W-1:0]     grant_s;
    logic                found_s;
    logic                heard_ena_s;
    logic [NUM_CHAN-1:0] push_s;
    logic [NUM_CHAN-1:0] pop_s;

    // Say-side decode: full-width range check, readiness from registered count only
    always_comb begin
        say_in_range_s = (say_meth < META_W'(NUM_CHAN));
        say_ch_s       = say_meth[CH_W-1:0];
        if (say_in_range_s) begin
            say_rdy_s = (count_r[say_ch_s] != CNT_FULL);
        end else begin
            say_rdy_s = 1'b1;
        end
        say_push_s = say__ENA & say_in_range_s & say_rdy_s;
        say_drop_s = say__ENA & ~say_in_range_s;
    end

    // Round-robin select: first non-empty channel after last_grant, wrapping
    always_comb begin : arb_sel
        int idx_v;
        grant_s = '0;
        found_s = 1'b0;
        idx_v   = 0;
        for (int k = 1; k <= NUM_CHAN; k++) begin
            idx_v = int'(last_grant_r) + k;
            idx_v = (idx_v >= NUM_CHAN) ? (idx_v - NUM_CHAN) : idx_v;
            if (!found_s && nonempty_r[CH_W'(idx_v)]) begin
                found_s = 1'b1;
                grant_s = CH_W'(idx_v);
            end else begin
                found_s = found_s;
                grant_s = grant_s;
            end
        end
        heard_ena_s = heard__RDY & found_s;
    end

    // Per-channel push/pop strobes and next occupancy
    always_comb begin
        for (int c = 0; c < NUM_CHAN; c++) begin
            push_s[c]       = say_push_s & (say_ch_s == CH_W'(c));
            pop_s[c]        = heard_ena_s & (grant_s == CH_W'(c));
            count_next_s[c] = count_r[c] + CNT_W'(push_s[c]) - CNT_W'(pop_s[c]);
        end
    end

    // Indication outputs are held at zero whenever no delivery happens
    always_comb begin
        if (heard_ena_s) begin
            heard_meth = META_W'(grant_s);
            heard_v    = mem_r[grant_s][rd_ptr_r[grant_s]];
        end else begin
            heard_meth = '0;
            heard_v    = '0;
        end
        heard__ENA = heard_ena_s;
        say__RDY   = say_rdy_s;
        nonempty   = nonempty_r;
        drop_count = drop_count_r;
    end

    // FIFO storage write; contents deliberately survive reset
    always_ff @(posedge CLK) begin
        if (say_push_s) begin
            mem_r[say_ch_s][wr_ptr_r[say_ch_s]] <= say_v;
        end
    end

    // Pointers, counts, occupancy flags, arbiter history and drop counter
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            for (int c = 0; c < NUM_CHAN; c++) begin
                wr_ptr_r[c] <= '0;
                rd_ptr_r[c] <= '0;
                count_r[c]  <= '0;
            end
            nonempty_r   <= '0;
            last_grant_r <= LAST_CH;
            drop_count_r <= 16'h0000;
        end else begin
            for (int c = 0; c < NUM_CHAN; c++) begin
                if (push_s[c]) begin
                    wr_ptr_r[c] <= (wr_ptr_r[c] + PTR_ONE) & PTR_MASK;
                end
                if (pop_s[c]) begin
                    rd_ptr_r[c] <= (rd_ptr_r[c] + PTR_ONE) & PTR_MASK;
                end
                count_r[c]    <= count_next_s[c];
                nonempty_r[c] <= (count_next_s[c] != '0);
            end
            if (heard_ena_s) begin
                last_grant_r <= grant_s;
            end
            if (say_drop_s && (drop_count_r != DROP_MAX)) begin
                drop_count_r <= drop_count_r + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_ivector_rr_dispatch.sv
// Bench for ivector_rr_dispatch (NUM_CHAN=10, DEPTH=4, DATA_W=32, META_W=32).
// A table of single-cycle vectors covers reset release, latency/order,
// simultaneous push/pop and drops; hand sequences cover full/drain,
// round-robin order, mid-operation reset and drop-counter saturation.
// A scoreboard of accepted says is matched against every heard delivery.
module tb_ivector_rr_dispatch;

    logic        CLK;
    logic        nRST;
    logic        say__ENA;
    logic [31:0] say_meth;
    logic [31:0] say_v;
    logic        say__RDY;
    logic        heard__ENA;
    logic [31:0] heard_meth;
    logic [31:0] heard_v;
    logic        heard__RDY;
    logic [9:0]  nonempty;
    logic [15:0] drop_count;

    int checks = 0;
    int errors = 0;

    ivector_rr_dispatch #(
        .NUM_CHAN(10), .DEPTH(4), .DATA_W(32), .META_W(32)
    ) dut (
        .CLK(CLK), .nRST(nRST),
        .say__ENA(say__ENA), .say_meth(say_meth), .say_v(say_v), .say__RDY(say__RDY),
        .heard__ENA(heard__ENA), .heard_meth(heard_meth), .heard_v(heard_v),
        .heard__RDY(heard__RDY), .nonempty(nonempty), .drop_count(drop_count)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: time limit reached, got no end, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic ena, input logic [31:0] m,
                         input logic [31:0] v, input logic hr);
        nRST = rst; say__ENA = ena; say_meth = m; say_v = v; heard__RDY = hr;
    endtask

    task automatic adv();
        @(posedge CLK);
        #1;
    endtask

    // Scoreboard of accepted in-range says, in acceptance order
    typedef struct packed {
        logic [31:0] ch;
        logic [31:0] v;
    } sb_t;
    sb_t sb_q[$];

    // Monitor: match deliveries against the scoreboard, then record new pushes
    always @(negedge CLK) begin
        if (!nRST) begin
            sb_q.delete();
        end else begin
            if (!heard__RDY) check("ena_without_rdy", {31'd0, heard__ENA}, 32'd0);
            if (heard__ENA) begin
                int idx;
                idx = -1;
                for (int i = 0; i < sb_q.size(); i++) begin
                    if (idx < 0 && sb_q[i].ch == heard_meth) idx = i;
                end
                if (idx < 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_missing: got heard meth %0d, required a queued entry", heard_meth);
                end else begin
                    check("sb_heard_v", heard_v, sb_q[idx].v);
                    sb_q.delete(idx);
                end
            end
            if (say__ENA && say_meth < 32'd10) begin
                sb_q.push_back('{ch: say_meth, v: say_v});
            end
        end
    end

    typedef struct {
        logic        nrst;
        logic        ena;
        logic [31:0] meth;
        logic [31:0] v;
        logic        hrdy;
        logic        e_rdy;
        logic        e_ena;
        logic [31:0] e_meth;
        logic [31:0] e_v;
        logic [9:0]  e_ne;
        logic [15:0] e_drop;
    } vec_t;

    vec_t vt[12];

    task automatic check_outs(input string tag, input logic e_rdy, input logic e_ena,
                              input logic [31:0] e_meth, input logic [31:0] e_v,
                              input logic [9:0] e_ne, input logic [15:0] e_drop);
        check({tag, "_say_rdy"},   {31'd0, say__RDY},   {31'd0, e_rdy});
        check({tag, "_heard_ena"}, {31'd0, heard__ENA}, {31'd0, e_ena});
        check({tag, "_heard_meth"}, heard_meth, e_meth);
        check({tag, "_heard_v"},    heard_v,    e_v);
        check({tag, "_nonempty"},  {22'd0, nonempty},   {22'd0, e_ne});
        check({tag, "_drop"},      {16'd0, drop_count}, {16'd0, e_drop});
    endtask

    logic [31:0] rr_meth [6];
    logic [31:0] rr_v    [6];

    initial begin
        //            nrst  ena   meth          v             hrdy  rdy   ena   meth    v       ne         drop
        vt[0]  = '{1'b1, 1'b0, 32'd2,        32'h0,        1'b0, 1'b1, 1'b0, 32'd0, 32'h0, 10'h000, 16'd0};
        vt[1]  = '{1'b1, 1'b1, 32'd3,        32'hA,        1'b1, 1'b1, 1'b0, 32'd0, 32'h0, 10'h000, 16'd0};
        vt[2]  = '{1'b1, 1'b1, 32'd3,        32'hB,        1'b1, 1'b1, 1'b1, 32'd3, 32'hA, 10'h008, 16'd0};
        vt[3]  = '{1'b1, 1'b0, 32'd3,        32'h0,        1'b1, 1'b1, 1'b1, 32'd3, 32'hB, 10'h008, 16'd0};
        vt[4]  = '{1'b1, 1'b0, 32'd3,        32'h0,        1'b1, 1'b1, 1'b0, 32'd0, 32'h0, 10'h000, 16'd0};
        vt[5]  = '{1'b1, 1'b1, 32'd2,        32'h6,        1'b0, 1'b1, 1'b0, 32'd0, 32'h0, 10'h000, 16'd0};
        vt[6]  = '{1'b1, 1'b1, 32'd2,        32'h7,        1'b1, 1'b1, 1'b1, 32'd2, 32'h6, 10'h004, 16'd0};
        vt[7]  = '{1'b1, 1'b0, 32'd2,        32'h0,        1'b1, 1'b1, 1'b1, 32'd2, 32'h7, 10'h004, 16'd0};
        vt[8]  = '{1'b1, 1'b1, 32'd12,       32'h99,       1'b1, 1'b1, 1'b0, 32'd0, 32'h0, 10'h000, 16'd0};
        vt[9]  = '{1'b1, 1'b1, 32'd10,       32'h1,        1'b0, 1'b1, 1'b0, 32'd0, 32'h0, 10'h000, 16'd1};
        vt[10] = '{1'b1, 1'b1, 32'h8000_0002, 32'h2,       1'b0, 1'b1, 1'b0, 32'd0, 32'h0, 10'h000, 16'd2};
        vt[11] = '{1'b1, 1'b0, 32'd2,        32'h0,        1'b0, 1'b1, 1'b0, 32'd0, 32'h0, 10'h000, 16'd3};

        rr_meth = '{32'd0, 32'd1, 32'd9, 32'd0, 32'd1, 32'd9};
        rr_v    = '{32'h100, 32'h110, 32'h190, 32'h101, 32'h111, 32'h191};

        // Reset held for 3 cycles while a say to channel 2 is presented
        drive(1'b0, 1'b1, 32'd2, 32'h55, 1'b0);
        repeat (3) adv();

        // Table-driven vectors
        for (int r = 0; r < 12; r++) begin
            drive(vt[r].nrst, vt[r].ena, vt[r].meth, vt[r].v, vt[r].hrdy);
            @(negedge CLK);
            check_outs($sformatf("vec%0d", r), vt[r].e_rdy, vt[r].e_ena, vt[r].e_meth,
                       vt[r].e_v, vt[r].e_ne, vt[r].e_drop);
            adv();
        end

        // Full channel: 4 entries into channel 5 with no downstream readiness
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 32'd5, 32'h50 + 32'(i), 1'b0);
            @(negedge CLK);
            check("full_fill_rdy", {31'd0, say__RDY}, 32'd1);
            adv();
        end
        drive(1'b1, 1'b0, 32'd5, 32'h0, 1'b0);
        @(negedge CLK);
        check("full_rdy_ch5", {31'd0, say__RDY}, 32'd0);
        check("full_nonempty", {22'd0, nonempty}, 32'h020);
        adv();
        drive(1'b1, 1'b0, 32'd6, 32'h0, 1'b0);
        @(negedge CLK);
        check("full_rdy_ch6", {31'd0, say__RDY}, 32'd1);
        adv();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 32'd5, 32'h0, 1'b1);
            @(negedge CLK);
            check("drain_rdy", {31'd0, say__RDY}, (i == 0) ? 32'd0 : 32'd1);
            check("drain_meth", heard_meth, 32'd5);
            check("drain_v", heard_v, 32'h50 + 32'(i));
            adv();
        end
        @(negedge CLK);
        check("drain_done_ena", {31'd0, heard__ENA}, 32'd0);
        check("drain_done_ne", {22'd0, nonempty}, 32'd0);
        adv();

        // Reset mid-operation discards a queued entry and restores channel 0 priority
        drive(1'b1, 1'b1, 32'd7, 32'h77, 1'b0);
        adv();
        drive(1'b0, 1'b0, 32'd0, 32'h0, 1'b0);
        adv();
        drive(1'b1, 1'b0, 32'd0, 32'h0, 1'b1);
        @(negedge CLK);
        check("rst_mid_ne", {22'd0, nonempty}, 32'd0);
        check("rst_mid_ena", {31'd0, heard__ENA}, 32'd0);
        check("rst_mid_drop", {16'd0, drop_count}, 32'd0);
        adv();

        // Round-robin: preload channels 0, 1, 9 with two entries each
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1, rr_meth[i], rr_v[i], 1'b0);
            adv();
        end
        drive(1'b1, 1'b0, 32'd0, 32'h0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            check("rr_ena", {31'd0, heard__ENA}, 32'd1);
            check("rr_meth", heard_meth, rr_meth[i]);
            check("rr_v", heard_v, rr_v[i]);
            adv();
        end
        @(negedge CLK);
        check("rr_done_ne", {22'd0, nonempty}, 32'd0);
        adv();

        // Drop counter saturation
        drive(1'b1, 1'b1, 32'd12, 32'h0, 1'b0);
        repeat (65534) adv();
        drive(1'b1, 1'b0, 32'd0, 32'h0, 1'b0);
        @(negedge CLK);
        check("drop_fffe", {16'd0, drop_count}, 32'h0000_FFFE);
        adv();
        drive(1'b1, 1'b1, 32'd12, 32'h0, 1'b0);
        adv();
        drive(1'b1, 1'b0, 32'd0, 32'h0, 1'b0);
        @(negedge CLK);
        check("drop_ffff", {16'd0, drop_count}, 32'h0000_FFFF);
        adv();
        drive(1'b1, 1'b1, 32'd12, 32'h0, 1'b0);
        adv();
        drive(1'b1, 1'b0, 32'd0, 32'h0, 1'b0);
        @(negedge CLK);
        check("drop_sat", {16'd0, drop_count}, 32'h0000_FFFF);
        check("drop_ne", {22'd0, nonempty}, 32'd0);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        adv();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
